div_iter: RTL
=============

# div_iter

Iterative restoring divider implementing 8086 DIV/IDIV for the ALU's mul/div group, replacing the zero-stubbed division paths. It divides a 2W-bit dividend by a W-bit divisor (word mode) or a W-bit dividend by a W/2-bit divisor (byte mode). Each quotient bit takes one cycle, and the block uses a start/done handshake. Divide errors (zero divisor, quotient overflow) go to the sequencer, which raises INT 0.

## Interface
Parameters:
- WIDTH, 16: divisor width in word mode. Must be even and at least 4.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  request pulse. Sampled only when busy=0.
- sgn  in  1  1=IDIV (signed), 0=DIV (unsigned). Sampled with start.
- word_op  in  1  1=word mode, 0=byte mode. Sampled with start.
- x  in  2*WIDTH  dividend. Byte mode uses x[WIDTH-1:0].
- y  in  WIDTH  divisor. Byte mode uses y[WIDTH/2-1:0].
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse. out and exc are valid in this cycle.
- out  out  2*WIDTH  result layout:
  - word mode: {rem[W-1:0], quo[W-1:0]}
  - byte mode: {W'b0, rem[W/2-1:0], quo[W/2-1:0]}
- exc  out  1  divide error. Meaningful only with done.

## Operation
- Inputs are captured in registers at the accepting edge. They may change afterwards.
- N = WIDTH (word mode) or WIDTH/2 (byte mode).
- States: IDLE, PREP, ITER, FIX, DONE.
  - IDLE: on start, go to PREP.
  - PREP:
    - In signed mode, convert dividend and divisor to magnitudes.
    - If divisor = 0, or the dividend's upper half (magnitude) ≥ divisor (magnitude), set exc and go to DONE.
    - Otherwise load the counter with N and go to ITER.
  - ITER:
    - Each cycle: shift the partial remainder left by 1, trial-subtract the divisor, restore on borrow, shift in one quotient bit.
    - Decrement the counter. Go to FIX when the counter reaches 0.
  - FIX:
    - Quotient sign = sign(x) XOR sign(y). Remainder sign = sign(x).
    - Signed range check: a quotient magnitude above 2^(N-1)-1 sets exc. This includes -2^(N-1), matching 8086 behaviour.
    - Go to DONE.
  - DONE:
    - done=1.
    - out holds the result, or all zeros if exc=1.
    - Next state is IDLE, or PREP if start=1 in this cycle.
- Arithmetic width: the partial remainder is N+1 bits. The unsigned result satisfies q·y + r = x with 0 ≤ r < y.
- start while busy=1 is ignored. No queueing.
- out and exc keep their values after DONE until the next accepted operation reaches DONE.

## Timing
- Reset values: state=IDLE, busy=0, done=0, exc=0, out=0, counter=0.
- Asserting rst at any point, including mid-ITER, aborts the operation. No done pulse is produced.
- Let E0 be the edge that accepts start.
  - busy rises after E0 and stays high through PREP, ITER and FIX.
  - busy is low in DONE and IDLE.
- Normal latency: done is high in the cycle after edge E0+N+2.
  - WIDTH=16: 18 cycles in word mode, 10 cycles in byte mode.
- Early error (zero divisor or upper-half overflow): done is high in the cycle after E0+1.
- Signed range overflow is detected in FIX, so it takes the full latency.
- Back-to-back operation: start asserted in the DONE cycle is accepted. The next PREP follows immediately, with no IDLE cycle.

## Configuration
- DIV_SIGNED_EN defined:
  - IDIV is supported: magnitude conversion, sign fix-up and the signed range check are all present.
- DIV_SIGNED_EN undefined:
  - sgn is ignored and every operation is unsigned.
  - FIX stays one cycle, so latency is identical.
  - No negation logic is built.

## Test plan
All scenarios use WIDTH=16.
- Unsigned word: x=32'h0001_0000, y=16'd3 -> out=32'h0001_5555, exc=0, done 18 cycles after start.
- Unsigned byte: x=32'h0000_03E8, y=16'h0007 -> out=32'h0000_068E, exc=0, done after 10 cycles.
- Signed word (DIV_SIGNED_EN defined):
  - x=32'hFFFF_FFF9, y=16'h0002 -> out=32'hFFFF_FFFD (q=-3, r=-1), exc=0.
  - x=32'h0000_8000, y=16'h0001 -> exc=1, out=0, done after 18 cycles.
- Divide by zero and early overflow:
  - y=0 -> exc=1, out=0, done after 2 cycles.
  - x=32'h0005_0000, y=16'd5 unsigned -> exc=1, done after 2 cycles.
- Handshake:
  - start pulses during ITER -> ignored; exactly one done pulse.
  - start asserted in the DONE cycle -> second result appears 18 cycles later.
- Reset mid-operation: rst at ITER cycle 5 -> busy=0 and out=0 on the next cycle; no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/div_iter.sv
// Iterative restoring divider for 8086 DIV/IDIV: one quotient bit per cycle, start/done handshake.
// Define DIV_SIGNED_EN to build IDIV support (magnitude conversion, sign fix-up, signed range check).
module div_iter #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sgn,
   input  logic                 word_op,
   input  logic [2*WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]     y,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   out,
   output logic                 exc
);

   localparam int W  = WIDTH;
   localparam int H  = WIDTH / 2;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            accept;

   logic            word_q;
   logic [2*W-1:0]  xa;
   logic [W-1:0]    ya;
   logic [W-1:0]    rem;
   logic [W-1:0]    quo;
   logic [W-1:0]    dv;

   logic            ext_s;
   logic [2*W-1:0]  xmag;
   logic [W-1:0]    ymag;
   logic [W-1:0]    hi_mag;
   logic [W-1:0]    lo_mag;
   logic            early_err;
   logic            rng_err;
   logic [W-1:0]    quo_res;
   logic [W-1:0]    rem_res;
   logic [2*W-1:0]  result;

   logic [W:0]      trial;
   logic            ge;
   logic [W-1:0]    diff;

`ifdef DIV_SIGNED_EN
   logic sgn_q;
   logic sign_x;
   logic sign_y;

   assign ext_s   = sgn;
   assign sign_x  = sgn_q & xa[2*W-1];
   assign sign_y  = sgn_q & ya[W-1];
   assign xmag    = sign_x ? -xa : xa;
   assign ymag    = sign_y ? -ya : ya;
   // A quotient magnitude of 2^(N-1) or more cannot be represented, even as -2^(N-1)
   assign rng_err = sgn_q & (word_q ? quo[W-1] : quo[H-1]);
   assign quo_res = (sign_x ^ sign_y) ? -quo : quo;
   assign rem_res = sign_x ? -rem : rem;
`else
   logic unused_sgn;

   assign unused_sgn = sgn;
   assign ext_s      = 1'b0;
   assign xmag       = xa;
   assign ymag       = ya;
   assign rng_err    = 1'b0;
   assign quo_res    = quo;
   assign rem_res    = rem;
`endif

   assign accept = start && ((state == IDLE) || (state == DONE));

   // Byte mode keeps the low dividend half left-aligned so the quotient lands in quo[H-1:0]
   assign hi_mag    = word_q ? xmag[2*W-1:W] : {{H{1'b0}}, xmag[W-1:H]};
   assign lo_mag    = word_q ? xmag[W-1:0]   : {xmag[H-1:0], {H{1'b0}}};
   assign early_err = (ymag == '0) || (hi_mag >= ymag);

   assign trial = {rem, quo[W-1]};
   assign ge    = trial >= {1'b0, dv};
   assign diff  = trial[W-1:0] - dv;

   assign result = word_q ? {rem_res, quo_res}
                          : {{W{1'b0}}, rem_res[H-1:0], quo_res[H-1:0]};

   // Control: state, handshake, counter and the registered result
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         exc   <= 1'b0;
         out   <= '0;
         cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= PREP;
                  busy  <= 1'b1;
               end
            end
            PREP: begin
               if (early_err) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  exc   <= 1'b1;
                  out   <= '0;
               end else begin
                  cnt   <= word_q ? CW'(W) : CW'(H);
                  state <= ITER;
               end
            end
            ITER: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= FIX;
            end
            FIX: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               exc   <= rng_err;
               out   <= rng_err ? '0 : result;
            end
            DONE: begin
               if (start) begin
                  state <= PREP;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath: operand capture, magnitude load and restoring iteration
   always_ff @(posedge clk) begin
      if (accept) begin
         word_q <= word_op;
         xa     <= word_op ? x : {{W{ext_s & x[W-1]}}, x[W-1:0]};
         ya     <= word_op ? y : {{H{ext_s & y[H-1]}}, y[H-1:0]};
`ifdef DIV_SIGNED_EN
         sgn_q  <= sgn;
`endif
      end
      if (state == PREP) begin
         rem <= hi_mag;
         quo <= lo_mag;
         dv  <= ymag;
      end
      if (state == ITER) begin
         rem <= ge ? diff : trial[W-1:0];
         quo <= {quo[W-2:0], ge};
      end
   end

endmodule
